// File: rtl/manual_badpixel_region_matcher_pkg.sv
// Shared definitions for the manual bad-pixel region matcher: FSM state
// encoding, line-cache region entry layout and default geometry constants.
package manual_badpixel_region_matcher_pkg;

  localparam int unsigned DEF_WIDTH_BITS    = 10;
  localparam int unsigned DEF_HEIGHT_BITS   = 10;
  localparam int unsigned DEF_BAD_POINT_NUM = 128;
  localparam int unsigned DEF_BAD_POINT_BIT = 7;
  localparam int unsigned DEF_IMAGE_WIDTH   = 640;
  localparam int unsigned DEF_IMAGE_HEIGHT  = 512;
  localparam int unsigned DEF_MAX_REGIONS   = 16;
  localparam int unsigned DEF_REGION_BITS   = 5;
  localparam int unsigned DEF_MAX_RADIUS    = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_READY = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One covered column span on a line, both ends inclusive.
  typedef struct packed {
    logic [DEF_WIDTH_BITS-1:0] x_end;
    logic [DEF_WIDTH_BITS-1:0] x_start;
  } region_t;

endpackage

// File: rtl/manual_badpixel_region_matcher_coord_ram.sv
// badpixel_coord_ram: simple dual-port coordinate table, one write port and
// one read port on a single clock, registered read (1-cycle latency).
// A read and write to the same address in one cycle returns the old data.
module manual_badpixel_region_matcher_coord_ram #(
  parameter int ADDR_BITS = 7,
  parameter int DEPTH     = 128,
  parameter int DATA_BITS = 20
) (
  input  logic                 clk,
  input  logic                 wen_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Storage write plus registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/manual_badpixel_region_matcher.sv
// Manual bad-pixel region matcher. For each image line a build cache of
// column spans is assembled by scanning the coordinate table; when the
// first pixel of that line arrives the build cache becomes the active cache
// and every pixel of the line is matched against it one cycle later.
// Handshake: pix_valid qualifies current_x/current_y for one cycle, there
// is no back-pressure; match_valid is pix_valid delayed by one cycle and
// qualifies bad_pixel_match in that same cycle.
module manual_badpixel_region_matcher
  import manual_badpixel_region_matcher_pkg::*;
#(
  parameter int WIDTH_BITS           = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS          = DEF_HEIGHT_BITS,
  parameter int BAD_POINT_NUM        = DEF_BAD_POINT_NUM,
  parameter int BAD_POINT_BIT        = DEF_BAD_POINT_BIT,
  parameter int IMAGE_WIDTH          = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT         = DEF_IMAGE_HEIGHT,
  parameter int MAX_REGIONS_PER_LINE = DEF_MAX_REGIONS,
  parameter int REGION_BITS          = DEF_REGION_BITS,
  parameter int MAX_RADIUS           = DEF_MAX_RADIUS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [WIDTH_BITS-1:0]    current_x,
  input  logic [HEIGHT_BITS-1:0]   current_y,
  input  logic [BAD_POINT_BIT:0]   bad_point_num,
  input  logic [2:0]               cfg_radius,
  input  logic                     wen_lut,
  input  logic [BAD_POINT_BIT-1:0] waddr_lut,
  input  logic [31:0]              wdata_lut,
  output logic                     bad_pixel_match,
  output logic                     match_valid,
  output logic                     region_overflow,
  output logic                     cache_miss,
  output logic                     busy,
  output state_e                   dbg_state
);

  localparam int XW   = WIDTH_BITS + 1;
  localparam int YW   = HEIGHT_BITS + 1;
  localparam int DW   = WIDTH_BITS + HEIGHT_BITS;
  localparam int IDXW = $clog2(MAX_REGIONS_PER_LINE);

  localparam logic [XW-1:0]            X_LAST   = XW'(IMAGE_WIDTH - 1);
  localparam logic [HEIGHT_BITS-1:0]   Y_LAST   = HEIGHT_BITS'(IMAGE_HEIGHT - 1);
  localparam logic [HEIGHT_BITS-1:0]   Y_ONE    = 1;
  localparam logic [BAD_POINT_BIT-1:0] A_ONE    = 1;
  localparam logic [BAD_POINT_BIT:0]   N_ONE    = 1;
  localparam logic [REGION_BITS-1:0]   C_ONE    = 1;
  localparam logic [REGION_BITS-1:0]   C_FULL   = REGION_BITS'(MAX_REGIONS_PER_LINE);
  localparam logic [2:0]               R_MAX    = 3'(MAX_RADIUS);

  state_e                   state_q;
  logic                     fs_q;
  logic [HEIGHT_BITS-1:0]   target_y_q;
  logic [BAD_POINT_BIT-1:0] scan_addr_q;
  logic                     rd_vld_q;
  logic [2:0]               radius_q;
  logic [REGION_BITS-1:0]   build_cnt_q;
  logic [REGION_BITS-1:0]   active_cnt_q;
  logic [HEIGHT_BITS-1:0]   active_tag_q;
  logic                     active_vld_q;
  logic                     overflow_q;
  logic                     miss_q;
  logic                     match_q;
  logic                     match_vld_q;
  region_t                  build_q  [MAX_REGIONS_PER_LINE];
  region_t                  active_q [MAX_REGIONS_PER_LINE];

  logic [DW-1:0]            ram_wdata;
  logic [DW-1:0]            ram_rdata;
  logic                     unused_wdata;

  assign ram_wdata    = {wdata_lut[16 +: HEIGHT_BITS], wdata_lut[0 +: WIDTH_BITS]};
  assign unused_wdata = ^{wdata_lut[31:16+HEIGHT_BITS], wdata_lut[15:WIDTH_BITS]};

  manual_badpixel_region_matcher_coord_ram #(
    .ADDR_BITS (BAD_POINT_BIT),
    .DEPTH     (BAD_POINT_NUM),
    .DATA_BITS (DW)
  ) u_coord_ram (
    .clk     (clk),
    .wen_i   (wen_lut),
    .waddr_i (waddr_lut),
    .wdata_i (ram_wdata),
    .raddr_i (scan_addr_q),
    .rdata_o (ram_rdata)
  );

  logic                   fs_rise;
  logic [2:0]             radius_cfg;
  logic [YW-1:0]          ty_w, py_w, ry_w;
  logic [XW-1:0]          px_w, rx_w, x_sum;
  logic                   row_hit;
  logic                   append_req;
  logic                   append_en;
  logic                   last_addr;
  logic                   swap;
  logic                   line_miss;
  logic                   active_hit;
  logic                   build_hit;
  logic                   match_d;
  region_t                new_region;

  assign fs_rise    = frame_start & ~fs_q;
  assign radius_cfg = (cfg_radius > R_MAX) ? R_MAX : cfg_radius;
  assign last_addr  = ({1'b0, scan_addr_q} == (bad_point_num - N_ONE));
  assign swap       = (state_q == S_READY) && pix_valid &&
                      (current_y == target_y_q) && !fs_rise;
  assign line_miss  = ((state_q == S_SCAN) || (state_q == S_DRAIN)) &&
                      pix_valid && (current_y == target_y_q);

  // Decode the table datum read last cycle into a row test and a clamped
  // column span; all sums are one bit wider so nothing wraps.
  always_comb begin
    ty_w  = {1'b0, target_y_q};
    py_w  = {1'b0, ram_rdata[WIDTH_BITS +: HEIGHT_BITS]};
    ry_w  = YW'(radius_q);
    px_w  = {1'b0, ram_rdata[0 +: WIDTH_BITS]};
    rx_w  = XW'(radius_q);
    x_sum = px_w + rx_w;
    row_hit = (py_w <= ty_w + ry_w) && (ty_w <= py_w + ry_w);
    new_region.x_start = (px_w >= rx_w) ? WIDTH_BITS'(px_w - rx_w) : '0;
    new_region.x_end   = (x_sum > X_LAST) ? WIDTH_BITS'(X_LAST) : WIDTH_BITS'(x_sum);
    append_req = rd_vld_q && row_hit && !fs_rise;
    append_en  = append_req && (build_cnt_q < C_FULL);
  end

  // Compare the current pixel against every valid span of both caches.
  always_comb begin
    active_hit = 1'b0;
    build_hit  = 1'b0;
    for (int i = 0; i < MAX_REGIONS_PER_LINE; i++) begin
      if ((REGION_BITS'(i) < active_cnt_q) &&
          (current_x >= active_q[i].x_start) && (current_x <= active_q[i].x_end)) begin
        active_hit = 1'b1;
      end
      if ((REGION_BITS'(i) < build_cnt_q) &&
          (current_x >= build_q[i].x_start) && (current_x <= build_q[i].x_end)) begin
        build_hit = 1'b1;
      end
    end
    // On the swap cycle the fresh build is what the line will use.
    if (swap) begin
      match_d = pix_valid && build_hit;
    end else begin
      match_d = pix_valid && active_vld_q && (active_tag_q == current_y) && active_hit;
    end
  end

  // Cache entry storage; validity is carried by the counts, so no reset.
  always_ff @(posedge clk) begin
    if (append_en) begin
      build_q[build_cnt_q[IDXW-1:0]] <= new_region;
    end
    if (swap) begin
      active_q <= build_q;
    end
  end

  // Build/swap controller plus registered match and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      // Starting high means a frame_start level held through reset is not
      // mistaken for a fresh edge.
      fs_q         <= 1'b1;
      target_y_q   <= '0;
      scan_addr_q  <= '0;
      rd_vld_q     <= 1'b0;
      radius_q     <= '0;
      build_cnt_q  <= '0;
      active_cnt_q <= '0;
      active_tag_q <= '0;
      active_vld_q <= 1'b0;
      overflow_q   <= 1'b0;
      miss_q       <= 1'b0;
      match_q      <= 1'b0;
      match_vld_q  <= 1'b0;
    end else begin
      fs_q        <= frame_start;
      match_vld_q <= pix_valid;
      match_q     <= match_d;
      rd_vld_q    <= 1'b0;
      if (fs_rise) begin
        target_y_q   <= '0;
        build_cnt_q  <= '0;
        scan_addr_q  <= '0;
        active_vld_q <= 1'b0;
        overflow_q   <= 1'b0;
        miss_q       <= 1'b0;
        radius_q     <= radius_cfg;
        state_q      <= S_SCAN;
      end else begin
        if (append_req) begin
          if (append_en) begin
            build_cnt_q <= build_cnt_q + C_ONE;
          end else begin
            overflow_q <= 1'b1;
          end
        end
        if (line_miss) begin
          miss_q <= 1'b1;
        end
        case (state_q)
          S_SCAN: begin
            if (bad_point_num == '0) begin
              state_q <= S_READY;
            end else begin
              rd_vld_q    <= 1'b1;
              scan_addr_q <= scan_addr_q + A_ONE;
              if (last_addr) begin
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: state_q <= S_READY;
          S_READY: begin
            if (swap) begin
              active_cnt_q <= build_cnt_q;
              active_tag_q <= target_y_q;
              active_vld_q <= 1'b1;
              if (target_y_q < Y_LAST) begin
                target_y_q  <= target_y_q + Y_ONE;
                build_cnt_q <= '0;
                scan_addr_q <= '0;
                radius_q    <= radius_cfg;
                state_q     <= S_SCAN;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bad_pixel_match = match_q;
  assign match_valid     = match_vld_q;
  assign region_overflow = overflow_q;
  assign cache_miss      = miss_q;
  assign busy            = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_manual_badpixel_region_matcher.sv
// Directed bench for the bad-pixel region matcher: drivers push the
// hand-derived match bit of every pixel into a queue, a monitor pops and
// compares whenever match_valid is seen.
module tb_manual_badpixel_region_matcher;
  import manual_badpixel_region_matcher_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  current_x = '0;
  logic [9:0]  current_y = '0;
  logic [7:0]  bad_point_num = '0;
  logic [2:0]  cfg_radius = '0;
  logic        wen_lut = 1'b0;
  logic [6:0]  waddr_lut = '0;
  logic [31:0] wdata_lut = '0;
  logic        bad_pixel_match, match_valid, region_overflow, cache_miss, busy;
  state_e      dbg_state;

  manual_badpixel_region_matcher dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .current_x(current_x), .current_y(current_y), .bad_point_num(bad_point_num),
    .cfg_radius(cfg_radius), .wen_lut(wen_lut), .waddr_lut(waddr_lut),
    .wdata_lut(wdata_lut), .bad_pixel_match(bad_pixel_match),
    .match_valid(match_valid), .region_overflow(region_overflow),
    .cache_miss(cache_miss), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard state
  logic [0:0] exp_q[$];
  int         cyc_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       busy_track = 1'b0;
  int         busy_run = 0;
  int         max_busy_run = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver tasks
  task automatic write_pt(input int addr, input int x, input int y);
    @(negedge clk);
    wen_lut = 1'b1;
    waddr_lut = 7'(addr);
    wdata_lut = {16'(y), 16'(x)};
    @(negedge clk);
    wen_lut = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic e);
    @(negedge clk);
    pix_valid = 1'b1;
    current_x = 10'(x);
    current_y = 10'(y);
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
  endtask

  task automatic pix_idle();
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic fs_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_state(input state_e st, input int budget, input string name);
    int n = 0;
    while (dbg_state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(dbg_state), int'(st));
  endtask

  // One pixel per line, away from any covered span, to step through lines.
  task automatic advance(input int y0, input int y1, input int x);
    for (int y = y0; y < y1; y++) begin
      wait_state(S_READY, 400, "build_ready");
      pix(x, y, 1'b0);
      pix_idle();
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Monitor: pop and compare on every match_valid.
      forever begin
        @(negedge clk);
        if (match_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_match_valid", 1, 0);
          end else begin
            logic [0:0] e;
            int         c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("match_latency", c, cyc - 1);
            chk("bad_pixel_match", int'(bad_pixel_match), int'(e));
          end
        end else begin
          if (bad_pixel_match) chk("match_without_valid", 1, 0);
          if (exp_q.size() > 0 && cyc_q[0] < cyc - 1) begin
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            chk("missing_match_valid", 0, 1);
          end
        end
        if (!busy_track) begin
          busy_run = 0;
          max_busy_run = 0;
        end else begin
          busy_run = busy ? busy_run + 1 : 0;
          if (busy_run > max_busy_run) max_busy_run = busy_run;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match_valid", int'(match_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(dbg_state), int'(S_IDLE));
    chk("rst_overflow", int'(region_overflow), 0);
    chk("rst_cache_miss", int'(cache_miss), 0);
    chk("rst_match", int'(bad_pixel_match), 0);

    // Point (100,50), R=2
    write_pt(0, 100, 50);
    bad_point_num = 8'd1;
    cfg_radius = 3'd2;
    fs_pulse();
    advance(0, 47, 600);
    for (int y = 47; y <= 53; y++) begin
      wait_state(S_READY, 400, "build_ready");
      for (int x = 97; x <= 103; x++) begin
        pix(x, y, (y >= 48 && y <= 52 && x >= 98 && x <= 102));
      end
      pix_idle();
    end
    chk("a_cache_miss", int'(cache_miss), 0);
    chk("a_overflow", int'(region_overflow), 0);

    // Image corners, R=3
    write_pt(0, 0, 0);
    write_pt(1, 639, 511);
    bad_point_num = 8'd2;
    cfg_radius = 3'd3;
    fs_pulse();
    wait_state(S_READY, 400, "build_ready");
    for (int x = 0; x <= 4; x++) pix(x, 0, (x <= 3));
    pix(636, 0, 1'b0);
    pix_idle();
    advance(1, 508, 300);
    wait_state(S_READY, 400, "build_ready");
    pix(635, 508, 1'b0);
    for (int x = 636; x <= 639; x++) pix(x, 508, 1'b1);
    pix_idle();
    advance(509, 511, 300);
    wait_state(S_READY, 400, "build_ready");
    pix(635, 511, 1'b0);
    for (int x = 636; x <= 639; x++) pix(x, 511, 1'b1);
    pix(0, 511, 1'b0);
    pix_idle();
    wait_state(S_DONE, 10, "last_line_done");

    // 20 points on line 10, R=0: only the first 16 fit
    for (int i = 0; i < 20; i++) write_pt(i, 5 + 10 * i, 10);
    bad_point_num = 8'd20;
    cfg_radius = 3'd0;
    fs_pulse();
    advance(0, 10, 600);
    wait_state(S_READY, 400, "build_ready");
    for (int i = 0; i < 20; i++) pix(5 + 10 * i, 10, (i < 16));
    pix_idle();
    chk("c_overflow_set", int'(region_overflow), 1);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("c_overflow_cleared", int'(region_overflow), 0);

    // Full table, pixels of line 1 arrive mid-build
    write_pt(0, 50, 1);
    write_pt(1, 60, 2);
    for (int i = 2; i < 128; i++) write_pt(i, i, 400);
    bad_point_num = 8'd128;
    cfg_radius = 3'd0;
    fs_pulse();
    wait_state(S_READY, 400, "build_ready");
    chk("d_cache_miss_before", int'(cache_miss), 0);
    pix(600, 0, 1'b0);
    for (int x = 48; x <= 52; x++) pix(x, 1, 1'b0);
    pix_idle();
    chk("d_cache_miss_set", int'(cache_miss), 1);
    wait_state(S_READY, 400, "build_ready");
    pix(50, 1, 1'b1);
    pix(51, 1, 1'b0);
    pix_idle();
    wait_state(S_READY, 400, "build_ready");
    pix(59, 2, 1'b0);
    pix(60, 2, 1'b1);
    pix(61, 2, 1'b0);
    pix_idle();

    // Reset during the build of line 5
    advance(3, 5, 600);
    repeat (5) @(negedge clk);
    chk("e_busy_mid_scan", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("e_busy_in_reset", int'(busy), 0);
    chk("e_state_in_reset", int'(dbg_state), int'(S_IDLE));
    chk("e_miss_in_reset", int'(cache_miss), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("e_idle_after_release", int'(dbg_state), int'(S_IDLE));
    chk("e_busy_after_release", int'(busy), 0);
    pix(50, 0, 1'b0);
    pix(50, 1, 1'b0);
    pix_idle();
    @(negedge clk);
    chk("e_no_swap_before_sof", int'(dbg_state), int'(S_IDLE));
    cfg_radius = 3'd1;
    fs_pulse();
    wait_state(S_READY, 400, "build_ready");
    for (int x = 48; x <= 52; x++) pix(x, 0, (x >= 49 && x <= 51));
    pix_idle();
    wait_state(S_READY, 400, "build_ready");
    pix(49, 1, 1'b1);
    pix(60, 1, 1'b1);
    pix(62, 1, 1'b0);
    pix_idle();

    // Empty table
    busy_track = 1'b1;
    bad_point_num = 8'd0;
    cfg_radius = 3'd0;
    fs_pulse();
    for (int y = 0; y < 4; y++) begin
      wait_state(S_READY, 20, "build_ready");
      pix(0, y, 1'b0);
      pix_idle();
      pix(5, y, 1'b0);
      pix(50, y, 1'b0);
      pix_idle();
    end
    repeat (3) @(negedge clk);
    chk("f_busy_max_run", max_busy_run, 1);
    chk("f_overflow", int'(region_overflow), 0);
    busy_track = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/manual_badpixel_region_matcher.md
MANUAL_BADPIXEL_REGION_MATCHER -- requirements
Module: manual_badpixel_region_matcher

Interface
REQ-001 SHALL have parameters: WIDTH_BITS=10 (X width); HEIGHT_BITS=10 (Y width); BAD_POINT_NUM=128 (table depth); BAD_POINT_BIT=7 (table address width); IMAGE_WIDTH=640; IMAGE_HEIGHT=512; MAX_REGIONS_PER_LINE=16; REGION_BITS=5 (count width, holds 0..16); MAX_RADIUS=7.
REQ-002 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (asynchronous, active-low); frame_start in 1 (SOF level, rising edge used); pix_valid in 1; current_x in WIDTH_BITS; current_y in HEIGHT_BITS; bad_point_num in BAD_POINT_BIT+1 (valid entries, 0..BAD_POINT_NUM); cfg_radius in 3 (region half-size R, 0..MAX_RADIUS); wen_lut in 1; waddr_lut in BAD_POINT_BIT; wdata_lut in 32 ({Y[31:16],X[15:0]}); bad_pixel_match out 1; match_valid out 1; region_overflow out 1; cache_miss out 1; busy out 1.

Function
REQ-003 SHALL hold an internal coordinate table of BAD_POINT_NUM entries written on clk when wen_lut=1, storing X[WIDTH_BITS-1:0] and Y[HEIGHT_BITS-1:0]; read latency 1 cycle.
REQ-004 Each point (x,y) SHALL cover rows [max(y-R,0), min(y+R,IMAGE_HEIGHT-1)] and columns [max(x-R,0), min(x+R,IMAGE_WIDTH-1)], R sampled from cfg_radius at build start; arithmetic one bit wider than operand, no wrap.
REQ-005 SHALL keep two line caches (active, build), each MAX_REGIONS_PER_LINE {x_end,x_start} entries, a count, and a line tag; active cache has a valid flag.
REQ-006 FSM states: IDLE, SCAN, DRAIN, READY, DONE.
REQ-007 IDLE: on frame_start rising edge -> target_y=0, build count=0, scan_addr=0, active invalid, go SCAN.
REQ-008 SCAN: read scan_addr each cycle, increment; after read of address bad_point_num-1 go DRAIN; if bad_point_num=0 go directly to READY with count 0.
REQ-009 Each read datum (one cycle after its address) SHALL be appended to build cache if its row range contains target_y; at count=MAX_REGIONS_PER_LINE further hits are dropped and region_overflow set (sticky).
REQ-010 DRAIN: process last datum, go READY; a build completes in bad_point_num+2 cycles from entering SCAN.
REQ-011 READY: when pix_valid=1 and current_y=target_y -> swap (build becomes active, tag=target_y, valid=1); then if target_y<IMAGE_HEIGHT-1 target_y+1, go SCAN, else go DONE.
REQ-012 DONE: idle until next frame_start rising edge, active cache retained.
REQ-013 Frame_start rising edge in any state SHALL abort the current build and restart as REQ-007; region_overflow and cache_miss cleared same cycle.
REQ-014 Match: bad_pixel_match and match_valid registered one cycle after pix_valid; match_valid=pix_valid delayed; bad_pixel_match=1 iff active valid, tag=current_y, and current_x within any valid region [x_start,x_end] inclusive.
REQ-015 In the swap cycle, the pixel SHALL be evaluated against the just-completed build cache.
REQ-016 If pix_valid=1 with current_y=target_y while state is SCAN or DRAIN, SHALL set cache_miss (sticky), output bad_pixel_match=0 for that line until swap, and swap on first line-target pixel after READY.
REQ-017 busy=1 in SCAN and DRAIN, else 0.
REQ-018 Table writes during SCAN are permitted; entries read before the write use old data.

Reset
REQ-019 rst_n low SHALL force state IDLE, all counts 0, active invalid, target_y 0, scan_addr 0, all outputs 0; table contents not cleared.
REQ-020 Reset asserted mid-build SHALL discard the build; no swap occurs after release until a new frame_start edge.

Structure
REQ-021 Shared package SHALL hold FSM state encoding, region entry layout ({x_end,x_start}) and default image/table constants.
REQ-022 One sub-module natural: badpixel_coord_ram (simple dual-port, 1-cycle read, single clock).

Verification
REQ-023 Point (100,50), R=2, N=1: line 50 pixels x=97..103 -> match only at x=98..102, one cycle later; lines 47 and 53 -> no match; lines 48..52 match.
REQ-024 Point (0,0), R=3: line 0 x=0..3 match, x=4 not; point (639,511) R=3: line 511 x=636..639 match, no out-of-range wrap.
REQ-025 20 points all at y=10 distinct x, R=0: line 10 first 16 matched, last 4 not, region_overflow=1; cleared on next frame_start edge.
REQ-026 N=128, line time 100 cycles: line 1 pixels arrive before build done -> cache_miss=1, no match on line 1 early pixels, correct matches on line 2.
REQ-027 Reset asserted during SCAN of line 5, released, frame_start edge -> line 0 cache rebuilt, matches correct, busy 0 after reset.
REQ-028 N=0: every pixel of frame -> bad_pixel_match=0, match_valid follows pix_valid, busy never high beyond one cycle.
